// File: rtl/wb_crc_pkg.sv
// Shared definitions for the wb_crc accelerator: register offsets, CTRL
// layout, engine state encoding and the bit-level CRC helper functions.
package wb_crc_pkg;

  // Word offsets (adr[3:2]).
  localparam logic [1:0] OFF_DATA  = 2'd0;
  localparam logic [1:0] OFF_CRC   = 2'd1;
  localparam logic [1:0] OFF_CTRL  = 2'd2;
  localparam logic [1:0] OFF_COUNT = 2'd3;

  // CTRL write: bit0 clears state to INIT and count to 0.
  localparam int CTRL_CLEAR_BIT = 0;

  // CTRL read layout.
  typedef struct packed {
    logic [29:0] rsvd;
    logic        busy;
    logic        zero;
  } ctrl_rd_t;

  typedef enum logic {
    ENG_IDLE = 1'b0,
    ENG_FOLD = 1'b1
  } eng_state_e;

  // Mask of the low w bits.
  function automatic logic [31:0] crc_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(i)] = b[3'(7 - i)];
    return r;
  endfunction

  // Reverse the low w bits of v; upper bits come back zero.
  function automatic logic [31:0] bitrev_n(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(w - 1 - i)] = v[5'(i)];
    end
    return r;
  endfunction

  // Fold one (already reflected, if needed) byte MSB-first into a w-bit state.
  function automatic logic [31:0] crc_fold_byte(input logic [31:0] state,
                                                input logic [7:0]  b,
                                                input logic [31:0] poly,
                                                input int          w);
    logic [31:0] s;
    logic [31:0] m;
    logic        fb;
    m = crc_mask(w);
    s = state & m;
    for (int i = 0; i < 8; i++) begin
      fb = s[5'(w - 1)] ^ b[3'(7 - i)];
      s  = ((s << 1) ^ (fb ? poly : 32'd0)) & m;
    end
    return s;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus, reduced to the signals the CRC slave uses.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:2]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
endinterface

// File: rtl/wb_crc_engine.sv
// CRC fold engine: holds the running state, the byte counter and a 4-lane
// byte queue. Each FOLD cycle consumes up to BPC queued lanes in ascending
// lane order; the FSM returns to IDLE when the lane mask empties.
module crc_engine
  import wb_crc_pkg::*;
#(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h04C1_1DB7,
  parameter logic [31:0] INIT  = 32'hFFFF_FFFF,
  parameter bit          REFIN = 1'b1,
  parameter int          BPC   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [31:0]      load_data_i,
  input  logic [3:0]       load_mask_i,
  input  logic             clear_i,
  input  logic             wr_state_i,
  input  logic [CRC_W-1:0] wr_state_val_i,
  output logic [CRC_W-1:0] state_o,
  output logic [31:0]      count_o,
  output eng_state_e       fsm_state_o
);

  localparam logic [2:0] BPC_N = 3'(BPC);

  eng_state_e       fsm_q, fsm_d;
  logic [CRC_W-1:0] state_q, state_d;
  logic [31:0]      count_q, count_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][7:0]  bytes_q, bytes_d;
  logic [31:0]      acc;
  logic [2:0]       nfold;

  // Next-state: fold queued lanes while in FOLD, otherwise apply register writes.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    bytes_d = bytes_q;
    acc     = 32'(state_q);
    nfold   = '0;
    if (fsm_q == ENG_FOLD) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[2'(i)] && (nfold < BPC_N)) begin
          acc = crc_fold_byte(acc, REFIN ? bitrev8(bytes_q[2'(i)]) : bytes_q[2'(i)],
                              POLY, CRC_W);
          mask_d[2'(i)] = 1'b0;
          nfold = nfold + 3'd1;
        end
      end
      state_d = acc[CRC_W-1:0];
      count_d = count_q + 32'(nfold);
      if (mask_d == 4'b0000) fsm_d = ENG_IDLE;
    end else begin
      if (clear_i) begin
        state_d = INIT[CRC_W-1:0];
        count_d = '0;
      end else if (wr_state_i) begin
        state_d = wr_state_val_i;
      end
      if (load_i) begin
        bytes_d = load_data_i;
        mask_d  = load_mask_i;
        if (|load_mask_i) fsm_d = ENG_FOLD;
      end
    end
  end

  // State registers; reset abandons any fold in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= ENG_IDLE;
      state_q <= INIT[CRC_W-1:0];
      count_q <= '0;
      mask_q  <= '0;
      bytes_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      bytes_q <= bytes_d;
    end
  end

  assign state_o     = state_q;
  assign count_o     = count_q;
  assign fsm_state_o = fsm_q;

endmodule

// File: rtl/wb_crc.sv
// Wishbone B4 pipelined CRC accelerator: register decode, one-cycle ack
// pipeline and readback mux around crc_engine.
//
// Handshake: an access is taken when cyc & stb & !stall. stall mirrors the
// engine's busy flag, so nothing is accepted (and nothing dropped) while a
// fold runs. ack pulses for one cycle exactly one cycle after acceptance,
// with dat_s valid in that cycle; back-to-back accepts give back-to-back acks.
module wb_crc
  import wb_crc_pkg::*;
#(
  parameter int          CRC_W  = 32,
  parameter logic [31:0] POLY   = 32'h04C1_1DB7,
  parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT = 32'hFFFF_FFFF,
  parameter bit          REFIN  = 1'b1,
  parameter bit          REFOUT = 1'b1,
  parameter int          BPC    = 1
) (
  input logic clk,
  input logic rst_n,
  wb_if.slave wb
);

  eng_state_e       eng_fsm;
  logic             busy;
  logic             accept, wr_en, rd_en;
  logic [CRC_W-1:0] state;
  logic [31:0]      count;
  logic [31:0]      crc_final;
  logic [31:0]      rdata;
  ctrl_rd_t         ctrl_rd;
  logic             ack_q;
  logic [31:0]      dat_s_q;

  assign busy   = (eng_fsm == ENG_FOLD);
  assign accept = wb.cyc & wb.stb & ~busy;
  assign wr_en  = accept & wb.we;
  assign rd_en  = accept & ~wb.we;

  crc_engine #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .INIT  (INIT),
    .REFIN (REFIN),
    .BPC   (BPC)
  ) u_eng (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_i         (wr_en && (wb.adr == OFF_DATA)),
    .load_data_i    (wb.dat_m),
    .load_mask_i    (wb.sel),
    .clear_i        (wr_en && (wb.adr == OFF_CTRL) && wb.dat_m[CTRL_CLEAR_BIT]),
    .wr_state_i     (wr_en && (wb.adr == OFF_CRC)),
    .wr_state_val_i (wb.dat_m[CRC_W-1:0]),
    .state_o        (state),
    .count_o        (count),
    .fsm_state_o    (eng_fsm)
  );

  // Readback value for the addressed register.
  always_comb begin
    crc_final = 32'(state);
    if (REFOUT) crc_final = bitrev_n(crc_final, CRC_W);
    crc_final = crc_final ^ (XOROUT & crc_mask(CRC_W));
    ctrl_rd      = '0;
    ctrl_rd.busy = busy;
    rdata = '0;
    case (wb.adr)
      OFF_CRC:   rdata = crc_final;
      OFF_CTRL:  rdata = ctrl_rd;
      OFF_COUNT: rdata = count;
      default:   rdata = '0;
    endcase
  end

  // Ack pipeline: capture read data on acceptance, present it with ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      dat_s_q <= '0;
    end else begin
      ack_q   <= accept;
      dat_s_q <= rd_en ? rdata : 32'd0;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.stall = busy;
  assign wb.dat_s = dat_s_q;

endmodule

// File: tb/tb_wb_crc.sv
// Bench for wb_crc: a CRC-32 instance (BPC=1) and a CRC-16/CCITT-FALSE
// instance (BPC=4). Directed table vectors, hand sequences for pipelining
// and reset, then random traffic against a table-driven reference model.
module tb_wb_crc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_if bus0();
  wb_if bus1();

  logic        m_cyc[2], m_stb[2], m_we[2];
  logic [3:2]  m_adr[2];
  logic [3:0]  m_sel[2];
  logic [31:0] m_dat[2];
  logic        s_ack[2], s_stall[2];
  logic [31:0] s_dat[2];

  assign bus0.cyc = m_cyc[0];  assign bus1.cyc = m_cyc[1];
  assign bus0.stb = m_stb[0];  assign bus1.stb = m_stb[1];
  assign bus0.we  = m_we[0];   assign bus1.we  = m_we[1];
  assign bus0.adr = m_adr[0];  assign bus1.adr = m_adr[1];
  assign bus0.sel = m_sel[0];  assign bus1.sel = m_sel[1];
  assign bus0.dat_m = m_dat[0]; assign bus1.dat_m = m_dat[1];
  assign s_ack[0] = bus0.ack;  assign s_ack[1] = bus1.ack;
  assign s_stall[0] = bus0.stall; assign s_stall[1] = bus1.stall;
  assign s_dat[0] = bus0.dat_s; assign s_dat[1] = bus1.dat_s;

  wb_crc u0 (.clk(clk), .rst_n(rst_n), .wb(bus0));

  wb_crc #(
    .CRC_W(16), .POLY(32'h0000_1021), .INIT(32'h0000_FFFF), .XOROUT(32'h0),
    .REFIN(1'b0), .REFOUT(1'b0), .BPC(4)
  ) u1 (.clk(clk), .rst_n(rst_n), .wb(bus1));

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc_now = 0;
  int busy_end[2];
  int acc0 = 0, acc1 = 0, ackc0 = 0, ackc1 = 0;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Count accepted requests and acks, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_cyc[0] && m_stb[0] && !s_stall[0]) acc0 <= acc0 + 1;
    if (m_cyc[1] && m_stb[1] && !s_stall[1]) acc1 <= acc1 + 1;
    if (s_ack[0]) ackc0 <= ackc0 + 1;
    if (s_ack[1]) ackc1 <= ackc1 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          md_w[2], md_bpc[2];
  logic [31:0] md_poly[2], md_init[2], md_xo[2];
  bit          md_ri[2], md_ro[2];
  logic [31:0] tbl[2][256];
  logic [31:0] st[2];
  logic [31:0] cnt[2];

  function automatic logic [31:0] mmask(input int b);
    return (md_w[b] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << md_w[b]) - 32'd1);
  endfunction

  function automatic logic [31:0] rev_bits(input logic [31:0] x, input int n);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((x >> i) & 32'd1);
    return r;
  endfunction

  // Classic MSB-first byte table.
  task automatic build_table(input int b);
    logic [31:0] r;
    for (int v = 0; v < 256; v++) begin
      r = 32'(v) << (md_w[b] - 8);
      for (int k = 0; k < 8; k++) begin
        if (((r >> (md_w[b] - 1)) & 32'd1) != 0) r = (r << 1) ^ md_poly[b];
        else r = r << 1;
        r = r & mmask(b);
      end
      tbl[b][v] = r;
    end
  endtask

  task automatic model_byte(input int b, input logic [7:0] d);
    logic [7:0] x;
    logic [7:0] idx;
    x = md_ri[b] ? 8'(rev_bits(32'(d), 8)) : d;
    idx = 8'((st[b] >> (md_w[b] - 8)) ^ 32'(x));
    st[b] = ((st[b] << 8) ^ tbl[b][idx]) & mmask(b);
    cnt[b] = cnt[b] + 1;
  endtask

  // Apply a write; returns how many cycles the engine stays busy.
  task automatic model_write(input int b, input logic [1:0] off, input logic [3:0] sel,
                             input logic [31:0] dat, output int ncyc);
    int n;
    n = 0;
    ncyc = 0;
    case (off)
      2'd0: begin
        for (int l = 0; l < 4; l++)
          if (((sel >> l) & 4'd1) != 0) begin
            model_byte(b, 8'(dat >> (8 * l)));
            n++;
          end
        ncyc = (n + md_bpc[b] - 1) / md_bpc[b];
      end
      2'd1: st[b] = dat & mmask(b);
      2'd2: if (dat[0]) begin st[b] = md_init[b]; cnt[b] = 0; end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input int b, input logic [1:0] off);
    logic [31:0] s;
    case (off)
      2'd1: begin
        s = md_ro[b] ? rev_bits(st[b], md_w[b]) : st[b];
        return s ^ (md_xo[b] & mmask(b));
      end
      2'd3: return cnt[b];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      st[b] = md_init[b];
      cnt[b] = 0;
      busy_end[b] = 0;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 of the ack cycle with the bus idle.
  task automatic wb_xfer(input string tag, input int b, input logic we, input logic [1:0] off,
                         input logic [3:0] sel, input logic [31:0] dat,
                         output logic [31:0] rdata, output int stalls);
    int exp_st;
    int ncyc;
    exp_st = busy_end[b] - cyc_now;
    if (exp_st < 0) exp_st = 0;
    m_cyc[b] = 1'b1; m_stb[b] = 1'b1; m_we[b] = we;
    m_adr[b] = off;  m_sel[b] = sel;  m_dat[b] = dat;
    stalls = 0;
    while (s_stall[b] && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, want low", tag, stalls);
    end
    @(posedge clk); #1;
    m_cyc[b] = 1'b0; m_stb[b] = 1'b0; m_we[b] = 1'b0;
    rdata = s_dat[b];
    check($sformatf("%s_ack", tag), 32'(s_ack[b]), 32'd1);
    check($sformatf("%s_stall", tag), 32'(stalls), 32'(exp_st));
    if (we) begin
      model_write(b, off, sel, dat, ncyc);
      if (off == 2'd0) busy_end[b] = cyc_now + ncyc;
    end else begin
      check($sformatf("%s_rd", tag), rdata, model_read(b, off));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          b;
    logic        we;
    logic [1:0]  off;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input int b, input logic we, input logic [1:0] off, input logic [3:0] sel,
                         input logic [31:0] dat, input bit chk, input logic [31:0] exp);
    vec_t v;
    v.b = b; v.we = we; v.off = off; v.sel = sel; v.dat = dat; v.chk = chk; v.exp = exp;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          sc;
    int          a0, k0;

    for (int b = 0; b < 2; b++) begin
      m_cyc[b] = 0; m_stb[b] = 0; m_we[b] = 0; m_adr[b] = 0; m_sel[b] = 0; m_dat[b] = 0;
    end
    md_w[0] = 32; md_poly[0] = 32'h04C1_1DB7; md_init[0] = 32'hFFFF_FFFF; md_xo[0] = 32'hFFFF_FFFF;
    md_ri[0] = 1; md_ro[0] = 1; md_bpc[0] = 1;
    md_w[1] = 16; md_poly[1] = 32'h0000_1021; md_init[1] = 32'h0000_FFFF; md_xo[1] = 32'h0;
    md_ri[1] = 0; md_ro[1] = 0; md_bpc[1] = 4;
    build_table(0);
    build_table(1);
    model_reset();

    // Reset values on the bus.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(s_ack[0]), 32'd0);
    check("rst_stall", 32'(s_stall[0]), 32'd0);
    check("rst_dat", s_dat[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state reads.
    add_vec(0, 0, 2'd1, 4'hF, 0, 1, 32'h0000_0000);
    add_vec(0, 0, 2'd3, 4'hF, 0, 1, 32'd0);
    add_vec(0, 0, 2'd2, 4'hF, 0, 1, 32'd0);
    add_vec(0, 0, 2'd0, 4'hF, 0, 1, 32'd0);
    // CRC-32 of "123456789".
    add_vec(0, 1, 2'd0, 4'hF, 32'h3433_3231, 0, 0);
    add_vec(0, 1, 2'd0, 4'hF, 32'h3837_3635, 0, 0);
    add_vec(0, 1, 2'd0, 4'h1, 32'h0000_0039, 0, 0);
    add_vec(0, 0, 2'd1, 4'hF, 0, 1, 32'hCBF4_3926);
    add_vec(0, 0, 2'd3, 4'hF, 0, 1, 32'd9);
    // Clear, no-op CTRL write, raw load, ignored COUNT write.
    add_vec(0, 1, 2'd2, 4'hF, 32'h1, 0, 0);
    add_vec(0, 0, 2'd1, 4'hF, 0, 1, 32'h0000_0000);
    add_vec(0, 0, 2'd3, 4'hF, 0, 1, 32'd0);
    add_vec(0, 1, 2'd1, 4'hF, 32'h1234_5678, 0, 0);
    add_vec(0, 1, 2'd2, 4'hF, 32'h0, 0, 0);
    add_vec(0, 1, 2'd3, 4'hF, 32'h55, 0, 0);
    // bitrev32(0x12345678) = 0x1E6A2C48, XOR 0xFFFFFFFF.
    add_vec(0, 0, 2'd1, 4'hF, 0, 1, 32'hE195_D3B7);
    add_vec(0, 0, 2'd3, 4'hF, 0, 1, 32'd0);
    // Sparse and empty sel: folds "1" then "3".
    add_vec(0, 1, 2'd2, 4'hF, 32'h1, 0, 0);
    add_vec(0, 1, 2'd0, 4'b0101, 32'h0033_0031, 0, 0);
    add_vec(0, 1, 2'd0, 4'b0000, 32'hDEAD_BEEF, 0, 0);
    add_vec(0, 0, 2'd1, 4'hF, 0, 0, 0);
    add_vec(0, 0, 2'd3, 4'hF, 0, 1, 32'd2);
    // CRC-16/CCITT-FALSE, four bytes per clock.
    add_vec(1, 0, 2'd1, 4'hF, 0, 1, 32'h0000_FFFF);
    add_vec(1, 1, 2'd0, 4'hF, 32'h3433_3231, 0, 0);
    add_vec(1, 1, 2'd0, 4'hF, 32'h3837_3635, 0, 0);
    add_vec(1, 1, 2'd0, 4'h1, 32'h0000_0039, 0, 0);
    add_vec(1, 0, 2'd1, 4'hF, 0, 1, 32'h0000_29B1);
    add_vec(1, 0, 2'd3, 4'hF, 0, 1, 32'd9);

    foreach (vt[i]) begin
      wb_xfer($sformatf("vec%0d", i), vt[i].b, vt[i].we, vt[i].off, vt[i].sel, vt[i].dat, rd, sc);
      if (vt[i].chk) check($sformatf("vec%0d_exp", i), rd, vt[i].exp);
    end

    // Pipelined read held behind a full-word fold.
    idle(1);
    a0 = acc0; k0 = ackc0;
    wb_xfer("pipe_wr", 0, 1, 2'd0, 4'hF, $urandom, rd, sc);
    wb_xfer("pipe_rd", 0, 0, 2'd1, 4'hF, 0, rd, sc);
    check("pipe_stall4", 32'(sc), 32'd4);
    idle(1);
    check("pipe_acks", 32'(ackc0 - k0), 32'd2);
    check("pipe_accepts", 32'(acc0 - a0), 32'd2);

    // Randomised traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      int          b, r;
      logic        we;
      logic [1:0]  off;
      logic [31:0] d;
      b = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      we = $urandom_range(0, 1) != 0;
      off = (r < 5) ? 2'd0 : 2'(r - 5);
      if (r >= 8) begin off = 2'd1; we = 1'b0; end
      d = $urandom;
      if (off == 2'd2 && we) d[0] = ($urandom_range(0, 3) == 0);
      wb_xfer($sformatf("rnd%0d", i), b, we, off, 4'($urandom_range(0, 15)), d, rd, sc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset asserted in the second cycle of a 4-byte fold.
    idle(6);
    wb_xfer("rstf_wr", 0, 1, 2'd0, 4'hF, 32'hA5A5_5A5A, rd, sc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_stall", 32'(s_stall[0]), 32'd0);
    check("rstf_ack", 32'(s_ack[0]), 32'd0);
    check("rstf_busy", 32'(u0.busy), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xfer("rstf_crc", 0, 0, 2'd1, 4'hF, 0, rd, sc);
    check("rstf_crc_exp", rd, 32'h0000_0000);
    wb_xfer("rstf_cnt", 0, 0, 2'd3, 4'hF, 0, rd, sc);
    check("rstf_cnt_exp", rd, 32'd0);

    idle(2);
    check("acks_bus0", 32'(ackc0), 32'(acc0));
    check("acks_bus1", 32'(ackc1), 32'(acc1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
